// File: rtl/lpc_dec.sv
// lpc_dec -- LPC speech synthesizer (decode side of the LPC encoder).
//
// Each accepted sample strobe builds one excitation value (an impulse train
// when the frame is voiced, +/- gain/4 LFSR noise when unvoiced). The value is
// passed through a 10th-order all-pole filter that uses a single time-shared
// multiplier, and one signed 16-bit sample comes out.
//
//   y[n] = round( (e << COEF_FRAC) - sum_{k=1..10} A_k * y[n-k] ) >> COEF_FRAC
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   v                one-cycle sample request; ignored (overrun) while busy
//   coef_load        one-cycle strobe capturing A1..A10, voiced, freq_count,
//                    gain into the pending set
//   A1..A10          signed Q2.13 predictor coefficients
//   voiced           frame voicing flag
//   freq_count       pitch period in samples (0 forces unvoiced)
//   gain             signed excitation amplitude
//   y, vout          output sample and its one-cycle valid pulse
//   busy             high while a sample is in flight
//   overrun          one-cycle pulse when a v was dropped
//
// Optional feature (macro LPC_DEC_SAT_EN): the rounded result is clipped to
// the 16-bit range instead of wrapping, and a sticky sat_flag output records
// any clip.
//
// Handshake: v is a request with no ready. It is accepted only in IDLE. The
// result appears on y with vout high exactly 13 cycles after the accepting
// edge. A v seen while busy is discarded and flagged on overrun.
module lpc_dec #(
    parameter int          COEF_FRAC = 13,
    parameter int          ORDER     = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               v,
    input  logic               coef_load,
    input  logic signed [15:0] A1,
    input  logic signed [15:0] A2,
    input  logic signed [15:0] A3,
    input  logic signed [15:0] A4,
    input  logic signed [15:0] A5,
    input  logic signed [15:0] A6,
    input  logic signed [15:0] A7,
    input  logic signed [15:0] A8,
    input  logic signed [15:0] A9,
    input  logic signed [15:0] A10,
    input  logic               voiced,
    input  logic [15:0]        freq_count,
    input  logic signed [15:0] gain,
    output logic signed [15:0] y,
    output logic               vout,
    output logic               busy,
`ifdef LPC_DEC_SAT_EN
    output logic               sat_flag,
`endif
    output logic               overrun
);

    typedef enum logic [1:0] {S_IDLE, S_EXC, S_MAC, S_OUT} state_t;

    state_t             state;
    logic        [3:0]  k;          // MAC tap index, 0-based (tap k+1)
    logic signed [39:0] acc;

    logic signed [15:0] a_in     [0:ORDER-1];
    logic signed [15:0] pend_a   [0:ORDER-1];
    logic signed [15:0] act_a    [0:ORDER-1];
    logic signed [15:0] hist     [0:ORDER-1];  // hist[i] = y[n-1-i]

    logic               pend_voiced, act_voiced;
    logic        [15:0] pend_freq,   act_freq;
    logic signed [15:0] pend_gain,   act_gain;

    logic        [15:0] pitch_cnt;
    logic        [15:0] lfsr;
    logic               fin;        // result sits in hist[0]; present it next cycle

    // Combinational datapath
    logic               voiced_eff;
    logic signed [15:0] gain_q;
    logic signed [15:0] e;
    logic        [15:0] pitch_nxt;
    logic signed [31:0] prod;
    logic signed [39:0] rnd;
    logic signed [39:0] r;
    logic signed [15:0] r16;
    logic               lfsr_fb;

    assign a_in[0] = A1;
    assign a_in[1] = A2;
    assign a_in[2] = A3;
    assign a_in[3] = A4;
    assign a_in[4] = A5;
    assign a_in[5] = A6;
    assign a_in[6] = A7;
    assign a_in[7] = A8;
    assign a_in[8] = A9;
    assign a_in[9] = A10;

    assign busy = (state != S_IDLE);

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign prod = act_a[k] * hist[k];

    always_comb begin
        voiced_eff = act_voiced && (act_freq != 16'd0);
        gain_q     = act_gain >>> 2;
        e          = '0;
        pitch_nxt  = '0;
        if (voiced_eff) begin
            e = (pitch_cnt == 16'd0) ? act_gain : 16'sd0;
            // >= rather than == so a period shortened mid-stream restarts cleanly
            pitch_nxt = (pitch_cnt >= act_freq - 16'd1) ? 16'd0 : pitch_cnt + 16'd1;
        end else begin
            e = lfsr[0] ? gain_q : -gain_q;
        end
    end

    always_comb begin
        rnd = acc + (40'sd1 <<< (COEF_FRAC - 1));
        r   = rnd >>> COEF_FRAC;
`ifdef LPC_DEC_SAT_EN
        if (r > 40'sd32767)
            r16 = 16'sh7FFF;
        else if (r < -40'sd32768)
            r16 = -16'sh8000;
        else
            r16 = r[15:0];
`else
        r16 = r[15:0];
`endif
    end

`ifndef LPC_DEC_SAT_EN
    // High bits of r are simply dropped by the two's-complement wrap.
    logic unused_r_hi;
    assign unused_r_hi = ^r[39:16];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            acc         <= '0;
            y           <= '0;
            vout        <= 1'b0;
            overrun     <= 1'b0;
            fin         <= 1'b0;
            pitch_cnt   <= '0;
            lfsr        <= LFSR_SEED;
            pend_voiced <= 1'b0;
            act_voiced  <= 1'b0;
            pend_freq   <= '0;
            act_freq    <= '0;
            pend_gain   <= '0;
            act_gain    <= '0;
            for (int i = 0; i < ORDER; i++) begin
                pend_a[i] <= '0;
                act_a[i]  <= '0;
                hist[i]   <= '0;
            end
`ifdef LPC_DEC_SAT_EN
            sat_flag    <= 1'b0;
`endif
        end else begin
            overrun <= v && (state != S_IDLE);
            vout    <= fin;
            fin     <= 1'b0;
            if (fin)
                y <= hist[0];

            if (coef_load) begin
                pend_voiced <= voiced;
                pend_freq   <= freq_count;
                pend_gain   <= gain;
                for (int i = 0; i < ORDER; i++)
                    pend_a[i] <= a_in[i];
            end

            case (state)
                S_IDLE: begin
                    if (v) begin
                        // A coef_load in the same cycle wins over the pending set.
                        if (coef_load) begin
                            act_voiced <= voiced;
                            act_freq   <= freq_count;
                            act_gain   <= gain;
                            for (int i = 0; i < ORDER; i++)
                                act_a[i] <= a_in[i];
                        end else begin
                            act_voiced <= pend_voiced;
                            act_freq   <= pend_freq;
                            act_gain   <= pend_gain;
                            for (int i = 0; i < ORDER; i++)
                                act_a[i] <= pend_a[i];
                        end
                        state <= S_EXC;
                    end
                end
                S_EXC: begin
                    acc       <= {{24{e[15]}}, e} <<< COEF_FRAC;
                    pitch_cnt <= pitch_nxt;
                    lfsr      <= {lfsr_fb, lfsr[15:1]};
                    k         <= '0;
                    state     <= S_MAC;
                end
                S_MAC: begin
                    acc <= acc - {{8{prod[31]}}, prod};
                    k   <= k + 4'd1;
                    if (k == 4'(ORDER - 1))
                        state <= S_OUT;
                end
                S_OUT: begin
                    hist[0] <= r16;
                    for (int i = 1; i < ORDER; i++)
                        hist[i] <= hist[i-1];
`ifdef LPC_DEC_SAT_EN
                    if (r16 != r[15:0] || r > 40'sd32767 || r < -40'sd32768)
                        sat_flag <= 1'b1;
`endif
                    fin   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
